// File: rtl/pgm_loader_pkg.sv
// Shared types for the program loader: top-level state encoding and the
// write-strobe phase codes used by the setup/strobe/hold sequencer.
package pgm_loader_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_ACCEPT,
        ST_WRITE,
        ST_CHECK,
        ST_FILL,
        ST_RELEASE,
        ST_RUN,
        ST_ERR
    } state_t;

    typedef enum logic [1:0] {
        PH_IDLE,
        PH_SETUP,
        PH_STROBE,
        PH_HOLD
    } phase_t;

endpackage

// File: rtl/pgm_loader_write_seq.sv
// IRAM write sequencer: SETUP (we_n=1) -> STROBE (we_n=0, one cycle) -> HOLD
// (we_n=1). A go seen during HOLD chains straight into the next SETUP so that
// back-to-back fill writes need no idle cycle.
module pgm_loader_write_seq
    import pgm_loader_pkg::*;
(
    input  logic clk,
    input  logic reset_n,
    input  logic go,
    output logic busy,
    output logic last_phase,
    output logic mem_we_n
);

    phase_t phase;

    assign busy       = (phase != PH_IDLE);
    assign last_phase = (phase == PH_HOLD);

    // Phase register and registered active-low write strobe.
    // NOTE: non-blocking assignments make every register see pre-edge values,
    // so phase and mem_we_n stay in lock-step regardless of statement order.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            phase    <= PH_IDLE;
            mem_we_n <= 1'b1;
        end else begin
            case (phase)
                PH_IDLE:   if (go) phase <= PH_SETUP;
                PH_SETUP:  begin
                    phase    <= PH_STROBE;
                    mem_we_n <= 1'b0;
                end
                PH_STROBE: begin
                    phase    <= PH_HOLD;
                    mem_we_n <= 1'b1;
                end
                PH_HOLD:   phase <= go ? PH_SETUP : PH_IDLE;
                default:   phase <= PH_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/pgm_loader.sv
// Program loader for instruction RAM: accepts a valid/ready word stream,
// writes it from address 0, zero-fills the rest of DEPTH, then hands the IRAM
// port back to the CPU and releases its reset RELEASE_DLY cycles later.
// Optional build macro LOADER_CHECKSUM_EN: after the last program word one
// extra beat is accepted and compared against the running sum of the words.
module pgm_loader
    import pgm_loader_pkg::*;
#(
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 10,
    parameter int DEPTH       = 1024,
    parameter int RELEASE_DLY = 2
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic              s_valid,
    input  logic [DATA_W-1:0] s_data,
    input  logic              s_last,
    output logic              s_ready,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we_n,
    output logic              override,
    output logic              cpu_reset,
    output logic              done,
    output logic              error,
    output logic [ADDR_W:0]   word_count,
    output logic [DATA_W-1:0] checksum
);

`ifdef LOADER_CHECKSUM_EN
    localparam bit CK_EN = 1'b1;
`else
    localparam bit CK_EN = 1'b0;
`endif

    localparam logic [ADDR_W-1:0] TOP_ADDR = ADDR_W'(DEPTH - 1);

    state_t            state;
    logic              last_q;
    logic [7:0]        rel_cnt;
    logic [DATA_W-1:0] checksum_q;

    logic seq_go, seq_busy, hold_done;
    logic accept_fire, check_fire, at_top, fin_now;

    pgm_loader_write_seq u_write_seq (
        .clk        (clk),
        .reset_n    (reset_n),
        .go         (seq_go),
        .busy       (seq_busy),
        .last_phase (hold_done),
        .mem_we_n   (mem_we_n)
    );

    assign checksum = CK_EN ? checksum_q : '0;

    // Handshakes and the "program done, move to fill or release" decision.
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        accept_fire = 1'b0;
        check_fire  = 1'b0;
        fin_now     = 1'b0;
        at_top      = (mem_addr == TOP_ADDR);
        if (state == ST_ACCEPT) accept_fire = s_ready && s_valid && !seq_busy;
        if (state == ST_CHECK)  check_fire  = s_ready && s_valid;
        if (state == ST_WRITE && hold_done && last_q && !CK_EN) fin_now = 1'b1;
        if (check_fire && s_data == checksum_q)                 fin_now = 1'b1;
        if (state == ST_FILL && hold_done)                      fin_now = 1'b1;
        seq_go = accept_fire || (fin_now && !at_top);
    end

    // Main loader FSM with registered outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= ST_IDLE;
            s_ready    <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            override   <= 1'b1;
            cpu_reset  <= 1'b1;
            done       <= 1'b0;
            error      <= 1'b0;
            word_count <= '0;
            checksum_q <= '0;
            last_q     <= 1'b0;
            rel_cnt    <= '0;
        end else begin
            case (state)
                ST_IDLE, ST_RUN, ST_ERR: begin
                    if (start) begin
                        state      <= ST_ACCEPT;
                        s_ready    <= 1'b1;
                        override   <= 1'b1;
                        cpu_reset  <= 1'b1;
                        done       <= 1'b0;
                        error      <= 1'b0;
                        mem_addr   <= '0;
                        word_count <= '0;
                        checksum_q <= '0;
                    end
                end
                ST_ACCEPT: begin
                    if (accept_fire) begin
                        mem_wdata  <= s_data;
                        word_count <= word_count + 1'b1;
                        checksum_q <= checksum_q + s_data;
                        last_q     <= s_last;
                        s_ready    <= 1'b0;
                        state      <= ST_WRITE;
                    end
                end
                ST_WRITE: begin
                    if (hold_done && !last_q) begin
                        if (at_top) begin
                            state <= ST_ERR;
                            error <= 1'b1;
                        end else begin
                            mem_addr <= mem_addr + 1'b1;
                            s_ready  <= 1'b1;
                            state    <= ST_ACCEPT;
                        end
                    end else if (hold_done && CK_EN) begin
                        s_ready <= 1'b1;
                        state   <= ST_CHECK;
                    end
                end
                ST_CHECK: begin
                    if (check_fire) begin
                        s_ready <= 1'b0;
                        if (s_data != checksum_q) begin
                            state <= ST_ERR;
                            error <= 1'b1;
                        end
                    end
                end
                ST_RELEASE: begin
                    if (rel_cnt == 8'(RELEASE_DLY - 1)) begin
                        cpu_reset <= 1'b0;
                        done      <= 1'b1;
                        state     <= ST_RUN;
                    end else begin
                        rel_cnt <= rel_cnt + 1'b1;
                    end
                end
                default: ;
            endcase

            if (fin_now) begin
                if (at_top) begin
                    state    <= ST_RELEASE;
                    override <= 1'b0;
                    rel_cnt  <= '0;
                end else begin
                    mem_addr  <= mem_addr + 1'b1;
                    mem_wdata <= '0;
                    state     <= ST_FILL;
                end
            end
        end
    end

endmodule
